// File: rtl/adc_scan_sequencer_if.sv
// ADC handshake and result stream bundle for the scan sequencer.
// The master side is the sequencer; the slave side is the ADC core plus
// the result consumer.
interface adc_scan_sequencer_if #(
  parameter int RESOLUTION = 8,
  parameter int NUM_CH     = 4
);
  localparam int CW = $clog2(NUM_CH);

  logic                  adc_start_o;
  logic                  adc_rdy_i;
  logic [RESOLUTION-1:0] adc_result_i;
  logic [CW-1:0]         ch_sel_o;
  logic                  data_valid_o;
  logic [CW-1:0]         data_ch_o;
  logic [RESOLUTION-1:0] data_o;
  logic                  scan_done_o;

  modport master (
    output adc_start_o, ch_sel_o, data_valid_o, data_ch_o, data_o, scan_done_o,
    input  adc_rdy_i, adc_result_i
  );

  modport slave (
    input  adc_start_o, ch_sel_o, data_valid_o, data_ch_o, data_o, scan_done_o,
    output adc_rdy_i, adc_result_i
  );
endinterface

// File: rtl/adc_scan_sequencer.sv
// Multi-channel SAR ADC scan sequencer: mux select, settle wait,
// start/ready/release handshake with timeout, 2^N averaging and a
// valid-only result stream.
module adc_scan_sequencer #(
  parameter int RESOLUTION = 8,
  parameter int NUM_CH     = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic                 trig_i,
  input  logic                 cont_i,
  input  logic [NUM_CH-1:0]    ch_mask_i,
  input  logic [1:0]           avg_log2_i,
  input  logic [3:0]           settle_i,
  adc_scan_sequencer_if.master bus,
  output logic                 busy_o,
  output logic                 timeout_o
);
  localparam int CW = $clog2(NUM_CH);
  localparam int AW = RESOLUTION + 3;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, SETTLE, CONV, RELEASE, CAPTURE} state_e;

  state_e                state_q, state_d;
  logic [NUM_CH-1:0]     mask_q;
  logic [1:0]            avg_q;
  logic [3:0]            settle_q, set_cnt_q, conv_cnt_q;
  logic [TW-1:0]         to_cnt_q;
  logic [CW-1:0]         ch_q, data_ch_q, first_ch, nxt_ch;
  logic [AW-1:0]         acc_q, acc_sum;
  logic [RESOLUTION-1:0] data_q;
  logic                  to_hit_q, abort_q, timeout_q, dvalid_q, done_q;
  logic                  has_nxt, last_conv;
  logic                  start_scan, adv_ch, emit, scan_end, to_now;

  // Lowest requested channel at scan start; descending loop so the lowest bit wins.
  always_comb begin
    first_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (ch_mask_i[i]) first_ch = CW'(i);
  end

  // Next enabled channel strictly above the current one in the latched mask.
  always_comb begin
    nxt_ch  = '0;
    has_nxt = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (mask_q[i] && CW'(i) > ch_q) begin
        nxt_ch  = CW'(i);
        has_nxt = 1'b1;
      end
  end

  // A timed-out conversion contributes zero to the average.
  assign acc_sum   = acc_q + (to_hit_q ? AW'(0) : AW'(bus.adc_result_i));
  assign last_conv = (conv_cnt_q == ((4'd1 << avg_q) - 4'd1));

  // Next-state and control strobes.
  always_comb begin
    state_d    = state_q;
    start_scan = 1'b0;
    adv_ch     = 1'b0;
    emit       = 1'b0;
    scan_end   = 1'b0;
    to_now     = 1'b0;
    unique case (state_q)
      IDLE: if (en_i && (trig_i || cont_i) && (ch_mask_i != '0)) begin
        start_scan = 1'b1;
        state_d    = SETTLE;
      end
      SETTLE: begin
        if (!en_i)                      state_d = IDLE;
        else if (set_cnt_q == settle_q) state_d = CONV;
      end
      CONV: begin
        if (bus.adc_rdy_i) state_d = RELEASE;
        else if (to_cnt_q == TW'(TIMEOUT - 1)) begin
          to_now  = 1'b1;
          state_d = RELEASE;
        end
      end
      RELEASE: state_d = CAPTURE;
      CAPTURE: begin
        // An abort lets the handshake finish, then drops the partial result.
        if (abort_q || !en_i)  state_d = IDLE;
        else if (!last_conv)   state_d = CONV;
        else begin
          emit = 1'b1;
          if (has_nxt) begin
            adv_ch  = 1'b1;
            state_d = SETTLE;
          end else begin
            scan_end = 1'b1;
            if (cont_i && (ch_mask_i != '0)) begin
              start_scan = 1'b1;
              state_d    = SETTLE;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;

  // Datapath: config latch, counters, accumulator and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mask_q     <= '0;
      avg_q      <= '0;
      settle_q   <= '0;
      ch_q       <= '0;
      set_cnt_q  <= '0;
      to_cnt_q   <= '0;
      conv_cnt_q <= '0;
      acc_q      <= '0;
      to_hit_q   <= 1'b0;
      abort_q    <= 1'b0;
      timeout_q  <= 1'b0;
      dvalid_q   <= 1'b0;
      done_q     <= 1'b0;
      data_q     <= '0;
      data_ch_q  <= '0;
    end else begin
      set_cnt_q <= (state_q == SETTLE) ? set_cnt_q + 4'd1 : 4'd0;
      to_cnt_q  <= (state_q == CONV) ? to_cnt_q + TW'(1) : '0;
      if (to_now)                  to_hit_q <= 1'b1;
      else if (state_q == CAPTURE) to_hit_q <= 1'b0;
      if (state_q == IDLE) abort_q <= 1'b0;
      else if (!en_i)      abort_q <= 1'b1;
      if (!en_i)       timeout_q <= 1'b0;
      else if (to_now) timeout_q <= 1'b1;
      if (start_scan) begin
        mask_q   <= ch_mask_i;
        avg_q    <= avg_log2_i;
        settle_q <= settle_i;
        ch_q     <= first_ch;
      end else if (adv_ch) begin
        ch_q <= nxt_ch;
      end
      if (start_scan || adv_ch) begin
        acc_q      <= '0;
        conv_cnt_q <= '0;
      end else if (state_q == CAPTURE) begin
        acc_q      <= acc_sum;
        conv_cnt_q <= conv_cnt_q + 4'd1;
      end
      if (emit) begin
        data_q    <= RESOLUTION'(acc_sum >> avg_q);
        data_ch_q <= ch_q;
      end
      dvalid_q <= emit;
      done_q   <= scan_end;
    end
  end

  assign bus.adc_start_o  = (state_q == CONV);
  assign bus.ch_sel_o     = ch_q;
  assign bus.data_valid_o = dvalid_q;
  assign bus.data_ch_o    = data_ch_q;
  assign bus.data_o       = data_q;
  assign bus.scan_done_o  = done_q;
  assign busy_o           = (state_q != IDLE);
  assign timeout_o        = timeout_q;
endmodule

// File: doc/adc_scan_sequencer.md
# adc_scan_sequencer

Multi-channel scan controller that sequences the SAR ADC block. It selects an analog input channel and waits a programmable settle time. It then runs the ADC start/ready/release handshake, optionally averages 2^N conversions per channel, and emits one result per enabled channel on a valid-only output stream. It sits between the configuration/trigger logic and the ADC core; the ADC and this block share clk_i and rst_ni.

## Interface
- RESOLUTION, 8: ADC result width; must match the ADC instance.
- NUM_CH, 4: number of analog channels, 2..16.
- TIMEOUT, 64: maximum cycles to wait for adc_rdy_i per conversion.
- CW = $clog2(NUM_CH) (localparam).

Ports:
- clk_i  in  1  clock; all logic on posedge.
- rst_ni  in  1  reset, asynchronous, active-low.
- en_i  in  1  sequencer enable.
- trig_i  in  1  single-scan trigger, level-sampled in IDLE.
- cont_i  in  1  continuous mode: rescan after each scan while high.
- ch_mask_i  in  NUM_CH  channels to convert; bit i = channel i.
- avg_log2_i  in  2  average 2^avg_log2_i conversions per channel (1..8).
- settle_i  in  4  extra mux settle cycles after each channel change.
- adc_start_o  out  1  ADC start request.
- adc_rdy_i  in  1  ADC conversion done.
- adc_result_i  in  RESOLUTION  ADC result (already polarity-corrected by ADC).
- ch_sel_o  out  CW  analog mux select.
- busy_o  out  1  high whenever state != IDLE.
- data_valid_o  out  1  one-cycle pulse: data_o/data_ch_o valid.
- data_ch_o  out  CW  channel of data_o.
- data_o  out  RESOLUTION  averaged result.
- scan_done_o  out  1  one-cycle pulse after the last channel of a scan.
- timeout_o  out  1  sticky error; cleared by en_i low or reset.

## Operation
- States: IDLE, SETTLE, CONV, RELEASE, CAPTURE.
- IDLE: when en_i=1, (trig_i|cont_i)=1 and ch_mask_i!=0, latch ch_mask_i, avg_log2_i and settle_i. Then set ch_sel_o to the lowest set mask bit, clear the accumulator and go to SETTLE. A zero mask means the trigger is ignored and the block stays in IDLE.
- SETTLE: lasts settle_i+1 cycles, then goes to CONV.
- CONV: adc_start_o=1 and a timeout counter runs. adc_rdy_i=1 moves to RELEASE. After TIMEOUT cycles without ready, set timeout_o and go to RELEASE anyway.
- RELEASE: adc_start_o=0 for one cycle, so the ADC latches its result and returns to idle. Then go to CAPTURE.
- CAPTURE: acc += adc_result_i; the timeout case adds 0.
  - Fewer than 2^avg conversions done: go to CONV.
  - Otherwise register data_o = acc >> avg (truncating) and data_ch_o = ch_sel_o, then pulse data_valid_o.
  - If a higher mask bit is set, select the next higher set channel, clear acc and go to SETTLE.
  - Otherwise pulse scan_done_o. If cont_i=1 and en_i=1, restart from the lowest latched channel (SETTLE, mask re-latched); else go to IDLE.
- Accumulator width is RESOLUTION+3, so it cannot overflow.
- en_i low mid-scan: a CONV in progress still completes RELEASE and CAPTURE, so the ADC is never left with start high. The partial accumulation is then discarded and the block goes to IDLE with no data_valid_o and no scan_done_o. In SETTLE, it goes to IDLE immediately.
- Config input changes during a scan have no effect until the next scan start, except cont_i, which is sampled at scan end.

## Timing
- Reset values: adc_start_o=0, ch_sel_o=0, busy_o=0, data_valid_o=0, data_ch_o=0, data_o=0, scan_done_o=0, timeout_o=0, state IDLE.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- Trigger sampled at edge 0 means SETTLE runs for cycles 1..settle_i+1 and CONV is entered at the next edge.
- With the RESOLUTION=8 ADC, adc_rdy_i rises 10 cycles after adc_start_o rises. Per conversion: CONV 11 cycles, then 1 RELEASE cycle and 1 CAPTURE cycle, so 13 cycles.
- data_valid_o is high in the cycle after the final CAPTURE. scan_done_o coincides with data_valid_o of the last channel.
- adc_start_o is high only in CONV. Every adc_start_o high period is followed by at least 2 low cycles.
- Reset mid-operation returns to reset values at once; there is no pending output.

## Test plan
- Single scan, mask=4'b0101, avg=0, settle=0, ADC model returns 8'h3C on ch0 and 8'hA5 on ch2 → exactly two data_valid_o pulses, (0, 3C) then (2, A5), 13+1 cycles apart. scan_done_o on the second pulse, and busy_o low the cycle after.
- Averaging: avg=2, ch1 only, model returns 10, 11, 12, 13 → four adc_start_o pulses, then data_o=11 and data_ch_o=1.
- Continuous: mask=4'b1000, cont_i=1 for 3 scans then 0 → three data_valid_o/scan_done_o pairs on ch3, each separated by settle_i+1+13 cycles, then IDLE.
- Timeout: model never asserts ready → adc_start_o drops after 64 cycles, timeout_o=1 (sticky), scan continues. Dropping en_i clears timeout_o.
- Abort: en_i dropped in the 5th CONV cycle → ADC handshake completes (RELEASE, CAPTURE), no data_valid_o, no scan_done_o, IDLE.
- Edge cases: mask=0 with trig_i=1 → busy_o stays 0. rst_ni pulsed low mid-CONV → all outputs return to reset values asynchronously, and a fresh trigger after reset produces correct results.
